// File: rtl/intr_debounce_pkg.sv
// intr_debounce_pkg
//   Shared constants and constant functions for the interrupt debounce block.
//   SYNC_STAGES : depth of the optional input synchronizer
//                 (used only when INTR_DEBOUNCE_SYNC_EN is defined).
//   clog2       : ceil(log2(v)).
//   max3        : largest of three integers. Used to size the shared counter width.
package intr_debounce_pkg;

  localparam int SYNC_STAGES = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/intr_debounce_ch.sv
// intr_debounce_ch
//   One interrupt channel. It contains an optional 2-flop synchronizer, a
//   hysteresis debounce counter, a pulse stretcher and a sticky pending bit.
//   The pulse stretcher and pending bit are active only in edge mode.
//   Optional feature macro: INTR_DEBOUNCE_SYNC_EN. When it is defined, in_i
//   passes through the synchronizer before it is sampled.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   in_i     raw interrupt line
//   clr_i    pending clear strobe (edge mode only)
//   out_o    filtered level (level mode) or stretched pulse (edge mode)
//   pend_o   registered pending bit
//   pend_d_o next-state pending bit, so the top can build a registered OR
module intr_debounce_ch
  import intr_debounce_pkg::*;
#(
  parameter int A_CNT     = 8,
  parameter int D_CNT     = 8,
  parameter int PULSE_LEN = 1,
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic in_i,
  input  logic clr_i,
  output logic out_o,
  output logic pend_o,
  output logic pend_d_o
);

  localparam int CW = clog2(max3(A_CNT, D_CNT, PULSE_LEN) + 1);
  localparam logic [CW-1:0] A_M1 = CW'(A_CNT - 1);
  localparam logic [CW-1:0] D_M1 = CW'(D_CNT - 1);
  localparam logic [CW-1:0] P_M1 = CW'(PULSE_LEN - 1);

  logic          smp;
  logic          s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          out_q, out_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] th_m1;
  logic          rise;

`ifdef INTR_DEBOUNCE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end
  assign smp = sync_q[SYNC_STAGES-1];
`else
  assign smp = in_i;
`endif

  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    rise   = 1'b0;
    th_m1  = s_q ? D_M1 : A_M1;
    // The count restarts whenever the sample agrees with the filtered state.
    // The state flips on the TH-th consecutive disagreeing sample.
    if (smp == s_q) begin
      cnt_d = '0;
    end else if (cnt_q == th_m1) begin
      s_d   = smp;
      cnt_d = '0;
      rise  = smp;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    pcnt_d = pcnt_q;
    out_d  = out_q;
    pend_d = pend_q;
    if (EDGE_MODE) begin
      // A rise (re)loads the stretcher, so a retrigger extends the pulse.
      if (rise) begin
        out_d  = 1'b1;
        pcnt_d = P_M1;
      end else if (pcnt_q != '0) begin
        pcnt_d = pcnt_q - 1'b1;
      end else begin
        out_d  = 1'b0;
      end
      // A set takes priority over a clear in the same cycle.
      pend_d = rise | (pend_q & ~clr_i);
    end else begin
      out_d  = s_d;
      pcnt_d = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_q    <= 1'b0;
      cnt_q  <= '0;
      pcnt_q <= '0;
      out_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign out_o    = out_q;
  assign pend_o   = pend_q;
  assign pend_d_o = pend_d;

endmodule

// File: rtl/intr_debounce.sv
// intr_debounce
//   N-channel interrupt debounce filter with assert/deassert hysteresis. Each
//   channel runs in level mode or edge mode. Edge-mode channels produce a
//   stretched pulse and set a sticky pending bit.
//   Optional feature macro: INTR_DEBOUNCE_SYNC_EN. When it is defined, each
//   input gets a 2-flop synchronizer, which adds 2 cycles to every latency.
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   intr_in    raw interrupt lines
//   intr_clr   per-channel pending clear strobes (ignored on level channels)
//   intr_out   filtered outputs
//   intr_pend  sticky pending bits (always 0 on level channels)
//   intr_any   registered OR of the pending bits
module intr_debounce
  import intr_debounce_pkg::*;
#(
  parameter int                  C_NUMBER       = 8,
  parameter int                  C_ASSERT_CNT   = 8,
  parameter int                  C_DEASSERT_CNT = 8,
  parameter logic [C_NUMBER-1:0] C_EDGE_MASK    = '0,
  parameter int                  C_PULSE_LEN    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [C_NUMBER-1:0] intr_in,
  input  logic [C_NUMBER-1:0] intr_clr,
  output logic [C_NUMBER-1:0] intr_out,
  output logic [C_NUMBER-1:0] intr_pend,
  output logic                intr_any
);

  logic [C_NUMBER-1:0] pend_d;
  logic                any_q;

  for (genvar i = 0; i < C_NUMBER; i++) begin : g_ch
    intr_debounce_ch #(
      .A_CNT    (C_ASSERT_CNT),
      .D_CNT    (C_DEASSERT_CNT),
      .PULSE_LEN(C_PULSE_LEN),
      .EDGE_MODE(C_EDGE_MASK[i])
    ) u_ch (
      .clk_i   (clk),
      .reset_i (reset),
      .in_i    (intr_in[i]),
      .clr_i   (intr_clr[i]),
      .out_o   (intr_out[i]),
      .pend_o  (intr_pend[i]),
      .pend_d_o(pend_d[i])
    );
  end

  // Built from the next-state pending bits, so intr_any moves on the same
  // edge as the pending bit that causes it.
  always_ff @(posedge clk) begin
    if (reset) any_q <= 1'b0;
    else       any_q <= |pend_d;
  end

  assign intr_any = any_q;

endmodule

// File: tb/tb_intr_debounce.sv
module tb_intr_debounce;

`ifdef INTR_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // Channels 0..3 are on u_dut0 (A=8, D=4, P=3, ch2/ch3 edge).
  // Channels 4..5 are on u_dut1 (A=1, D=1, P=3, ch4 edge).
  localparam int NCH = 6;
  localparam int THA [NCH] = '{8, 8, 8, 8, 1, 1};
  localparam int THD [NCH] = '{4, 4, 4, 4, 1, 1};
  localparam int PL  [NCH] = '{3, 3, 3, 3, 3, 3};
  localparam bit EDG [NCH] = '{0, 0, 1, 1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] x, clr;
  logic [3:0] o0, p0;
  logic [1:0] o1, p1;
  logic       a0, a1;
  logic [5:0] got_out, got_pend;
  logic [1:0] got_any;
  assign got_out  = {o1, o0};
  assign got_pend = {p1, p0};
  assign got_any  = {a1, a0};

  intr_debounce #(.C_NUMBER(4), .C_ASSERT_CNT(8), .C_DEASSERT_CNT(4),
                  .C_EDGE_MASK(4'b1100), .C_PULSE_LEN(3)) u_dut0 (
    .clk(clk), .reset(rst), .intr_in(x[3:0]), .intr_clr(clr[3:0]),
    .intr_out(o0), .intr_pend(p0), .intr_any(a0));

  intr_debounce #(.C_NUMBER(2), .C_ASSERT_CNT(1), .C_DEASSERT_CNT(1),
                  .C_EDGE_MASK(2'b01), .C_PULSE_LEN(3)) u_dut1 (
    .clk(clk), .reset(rst), .intr_in(x[5:4]), .intr_clr(clr[5:4]),
    .intr_out(o1), .intr_pend(p1), .intr_any(a1));

  int checks = 0;
  int errors = 0;

  // Reference model. Each channel keeps its sample history since the last
  // state change. The state flips once the last TH samples all differ from it.
  // An edge-mode pulse lasts until the last rise + PL - 1.
  logic [5:0] m_s, m_out, m_pend, m_ff1, m_ff2;
  logic [1:0] m_any;
  int         m_end [NCH];
  int         m_t = 0;
  bit         hist [NCH][$];

  task automatic model_edge(input logic [5:0] xi, input logic [5:0] ci, input logic ri);
    logic smp;
    bit   rose, ok;
    int   th;
    m_t++;
    for (int c = 0; c < NCH; c++) begin
      if (ri) begin
        m_s[c] = 0; m_out[c] = 0; m_pend[c] = 0; m_ff1[c] = 0; m_ff2[c] = 0;
        m_end[c] = -1; hist[c].delete();
      end else begin
`ifdef INTR_DEBOUNCE_SYNC_EN
        smp = m_ff2[c]; m_ff2[c] = m_ff1[c]; m_ff1[c] = xi[c];
`else
        smp = xi[c];
`endif
        rose = 0;
        hist[c].push_back(smp);
        if (hist[c].size() > 16) void'(hist[c].pop_front());
        th = m_s[c] ? THD[c] : THA[c];
        if (hist[c].size() >= th) begin
          ok = 1;
          for (int k = hist[c].size() - th; k < hist[c].size(); k++)
            if (hist[c][k] == m_s[c]) ok = 0;
          if (ok) begin
            m_s[c] = ~m_s[c];
            rose = m_s[c];
            hist[c].delete();
          end
        end
        if (EDG[c]) begin
          if (rose) m_end[c] = m_t + PL[c] - 1;
          m_out[c] = (m_t <= m_end[c]);
          if (rose) m_pend[c] = 1;
          else if (ci[c]) m_pend[c] = 0;
        end else begin
          m_out[c]  = m_s[c];
          m_pend[c] = 0;
        end
      end
    end
    m_any = {|m_pend[5:4], |m_pend[3:0]};
  endtask

  task automatic step(input logic [5:0] xi, input logic [5:0] ci, input logic ri);
    x = xi; clr = ci; rst = ri;
    @(posedge clk);
    model_edge(xi, ci, ri);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(6'h3f, 6'h00, 1'b1);
    checks++;
    if ({got_out, got_pend, got_any} !== 14'h0) begin
      errors++;
      $display("FAIL reset out=%b pend=%b any=%b required 0", got_out, got_pend, got_any);
    end
    step(6'h00, 6'h00, 1'b0);
    checks++;
    if ({got_out, got_pend, got_any} !== {m_out, m_pend, m_any}) begin
      errors++;
      $display("FAIL reset_release out=%b/%b pend=%b/%b any=%b/%b", got_out, m_out, got_pend, m_pend, got_any, m_any);
    end
  endtask

  task automatic test_level();
    for (int k = 0; k < 7; k++) step(6'h01, 6'h00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(6'h00, 6'h00, 1'b0);
      checks++;
      if (got_out[0] !== 1'b0 || got_out !== m_out) begin
        errors++;
        $display("FAIL level_7hi t=%0d out=%b required %b", m_t, got_out, m_out);
      end
    end
    for (int k = 1; k <= 11 + LAT; k++) begin
      step(6'h01, 6'h00, 1'b0);
      checks++;
      if (got_out[0] !== (k >= 8 + LAT) || got_out !== m_out) begin
        errors++;
        $display("FAIL level_rise k=%0d out=%b required %b", k, got_out, m_out);
      end
    end
    for (int k = 1; k <= 6 + LAT; k++) begin
      step(6'h00, 6'h00, 1'b0);
      checks++;
      if (got_out[0] !== (k < 4 + LAT) || got_out !== m_out) begin
        errors++;
        $display("FAIL level_fall k=%0d out=%b required %b", k, got_out, m_out);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 100; k++) begin
      step({4'h0, k[0], 1'b0}, 6'h00, 1'b0);
      checks++;
      if (got_out[1] !== 1'b0 || got_out !== m_out) begin
        errors++;
        $display("FAIL glitch k=%0d out=%b required %b", k, got_out, m_out);
      end
    end
  endtask

  task automatic test_edge();
    int hi;
    hi = 0;
    for (int k = 0; k < 7 + LAT; k++) step(6'h04, 6'h00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(6'h04, 6'h00, 1'b0);
      hi += int'(got_out[2]);
      checks++;
      if ({got_out, got_pend, got_any} !== {m_out, m_pend, m_any}) begin
        errors++;
        $display("FAIL edge t=%0d out=%b/%b pend=%b/%b any=%b/%b", m_t, got_out, m_out, got_pend, m_pend, got_any, m_any);
      end
    end
    checks++;
    if (hi != 3 || got_pend[2] !== 1'b1 || got_any[0] !== 1'b1) begin
      errors++;
      $display("FAIL edge_pulse high=%0d pend=%b any=%b required 3/1/1", hi, got_pend[2], got_any[0]);
    end
    step(6'h04, 6'h04, 1'b0);
    checks++;
    if (got_pend[2] !== 1'b0 || got_any[0] !== 1'b0 || got_pend !== m_pend) begin
      errors++;
      $display("FAIL edge_clr pend=%b any=%b required 0/0", got_pend[2], got_any[0]);
    end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 6 + LAT; k++) step(6'h00, 6'h00, 1'b0);
    for (int k = 1; k <= 8 + LAT; k++) begin
      step(6'h04, (k == 8 + LAT) ? 6'h04 : 6'h00, 1'b0);
      checks++;
      if ({got_out, got_pend, got_any} !== {m_out, m_pend, m_any}) begin
        errors++;
        $display("FAIL same_cycle k=%0d out=%b/%b pend=%b/%b any=%b/%b", k, got_out, m_out, got_pend, m_pend, got_any, m_any);
      end
    end
    checks++;
    if (got_pend[2] !== 1'b1 || got_any[0] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins pend=%b any=%b required 1/1", got_pend[2], got_any[0]);
    end
    step(6'h04, 6'h04, 1'b0);
  endtask

  task automatic test_retrigger();
    logic [7:0] pat;
    int hi;
    pat = 8'b0000_0101;
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      step({1'b0, (k < 8) ? pat[k] : 1'b0, 4'h4}, 6'h00, 1'b0);
      hi += int'(got_out[4]);
      checks++;
      if ({got_out, got_pend, got_any} !== {m_out, m_pend, m_any}) begin
        errors++;
        $display("FAIL retrig k=%0d out=%b/%b pend=%b/%b", k, got_out, m_out, got_pend, m_pend);
      end
    end
    checks++;
    if (hi != 5) begin
      errors++;
      $display("FAIL retrig_len high=%0d required 5", hi);
    end
    step(6'h04, 6'h10, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6 + LAT; k++) step(6'h00, 6'h00, 1'b0);
    for (int k = 0; k < 5; k++) step(6'h01, 6'h00, 1'b0);
    step(6'h01, 6'h00, 1'b1);
    checks++;
    if ({got_out, got_pend, got_any} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid out=%b pend=%b any=%b required 0", got_out, got_pend, got_any);
    end
    for (int k = 1; k <= 9 + LAT; k++) begin
      step(6'h01, 6'h00, 1'b0);
      checks++;
      if (got_out[0] !== (k >= 8 + LAT) || got_out !== m_out) begin
        errors++;
        $display("FAIL reset_mid_rise k=%0d out=%b required %b", k, got_out, m_out);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] xv, cv;
    logic       rv;
    xv = 6'h00;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 5) == 0) xv[c] = ~xv[c];
      for (int c = 0; c < NCH; c++) cv[c] = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 299) == 0);
      step(xv, cv, rv);
      checks++;
      if ({got_out, got_pend, got_any} !== {m_out, m_pend, m_any}) begin
        errors++;
        $display("FAIL random t=%0d out=%b/%b pend=%b/%b any=%b/%b", m_t, got_out, m_out, got_pend, m_pend, got_any, m_any);
      end
    end
  endtask

  initial begin
    rst = 1'b1; x = '0; clr = '0;
    test_reset();
    test_level();
    test_glitch();
    test_edge();
    test_same_cycle();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
